// File: rtl/count_check_pkg.sv
// Shared types and constants for the down-counter checker.
package count_check_pkg;

  // Checker FSM states
  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  // Width of the saturating error / wrap tallies
  localparam int TALLY_W = 8;

  // Width of the consecutive-miss counter; holds FAULT_RUN up to 15
  localparam int MISS_W = 4;

  // Largest tally value; the counters stick here
  localparam logic [TALLY_W-1:0] TALLY_MAX = {TALLY_W{1'b1}};

  // Saturating increment used by the tally counters
  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] v);
    return (v == TALLY_MAX) ? v : v + TALLY_W'(1);
  endfunction

endpackage

// File: rtl/down_count_checker_sat_counter8.sv
// 8-bit saturating event counter with synchronous clear.
module sat_counter8
  import count_check_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_clr,
  input  logic               i_inc,
  output logic [TALLY_W-1:0] o_value
);

  logic [TALLY_W-1:0] r_value;

  // Clear wins over increment; increment sticks at the maximum
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (i_clr) begin
      r_value <= '0;
    end else if (i_inc) begin
      r_value <= sat_inc(r_value);
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/down_count_checker.sv
// Self-checking monitor for a synchronous down counter: predicts count-1
// each enabled sample, flags mismatches, tallies errors and wraps, and
// latches a sticky fault after FAULT_RUN consecutive misses.
module down_count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int FAULT_RUN = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_dut_rst,
  input  logic [WIDTH-1:0]   i_count,
  output logic               o_locked,
  output logic               o_error,
  output logic               o_fault,
  output logic [TALLY_W-1:0] o_err_cnt,
  output logic [TALLY_W-1:0] o_wrap_cnt
);

  localparam logic [MISS_W-1:0] LP_FAULT_RUN = MISS_W'(FAULT_RUN);

  state_e              r_state;
  logic [WIDTH-1:0]    r_exp;
  logic [MISS_W-1:0]   r_miss;
  logic                r_locked;
  logic                r_error;
  logic                r_fault;

  logic [WIDTH-1:0]    w_pred;
  logic                w_match;
  logic                w_sample;
  logic                w_err_inc;
  logic                w_wrap_inc;
  logic [MISS_W-1:0]   w_miss_next;
  logic                w_fault_hit;

  // Prediction, comparison and tally increment requests for this sample
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_pred      = i_count - WIDTH'(1);
    w_match     = (i_count == r_exp);
    w_sample    = 1'b0;
    w_err_inc   = 1'b0;
    w_wrap_inc  = 1'b0;
    w_miss_next = r_miss + MISS_W'(1);
    w_fault_hit = (w_miss_next == LP_FAULT_RUN);
    // A compared sample exists only in TRACK with no reset of any kind
    if ((r_state == ST_TRACK) && !i_rst && !i_dut_rst && i_en) begin
      w_sample = 1'b1;
    end
    if (w_sample) begin
      w_err_inc  = !w_match;
      w_wrap_inc = w_match && (i_count == '0);
    end
  end

  // Checker FSM with prediction register, miss run and registered flags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_SYNC;
      r_exp    <= '0;
      r_miss   <= '0;
      r_locked <= 1'b0;
      r_error  <= 1'b0;
      r_fault  <= 1'b0;
    end else begin
      r_error <= 1'b0;
      case (r_state)
        ST_FAULT: begin
          // Absorbing: only i_rst leaves this state
          r_locked <= 1'b0;
          r_fault  <= 1'b1;
        end
        default: begin
          if (i_dut_rst) begin
            // Counter is being reset: drop lock and wait for a fresh seed
            r_state  <= ST_SYNC;
            r_miss   <= '0;
            r_locked <= 1'b0;
          end else if (i_en) begin
            if (r_state == ST_SYNC) begin
              // Seed sample: no comparison, just learn the next value
              r_exp    <= w_pred;
              r_miss   <= '0;
              r_state  <= ST_TRACK;
              r_locked <= 1'b1;
            end else if (w_match) begin
              r_exp  <= w_pred;
              r_miss <= '0;
            end else begin
              // Re-seed from the observed value so one glitch costs one error
              r_error <= 1'b1;
              r_exp   <= w_pred;
              r_miss  <= w_miss_next;
              if (w_fault_hit) begin
                r_state  <= ST_FAULT;
                r_fault  <= 1'b1;
                r_locked <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  sat_counter8 u_err_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_err_inc),
    .o_value (o_err_cnt)
  );

  sat_counter8 u_wrap_cnt (
    .i_clk   (i_clk),
    .i_clr   (i_rst),
    .i_inc   (w_wrap_inc),
    .o_value (o_wrap_cnt)
  );

  assign o_locked = r_locked;
  assign o_error  = r_error;
  assign o_fault  = r_fault;

endmodule
